// File: rtl/nios2_div_pkg.sv
// rtl/nios2_div_pkg.sv - shared constants and state type for the Nios II divider cell
package nios2_div_pkg;

    localparam int DIV_DATA_W  = 32;
    localparam int DIV_ITERS   = DIV_DATA_W;
    localparam int DIV_CNT_W   = $clog2(DIV_ITERS);
    localparam int DIV_LATENCY = DIV_ITERS + 3;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        CALC,
        FIXUP
    } div_state_e;

endpackage

// File: rtl/nios2_div_step.sv
// rtl/nios2_div_step.sv - one combinational radix-2 restoring division step
module nios2_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_in,
    input  logic         q_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // rem_in < divisor, so the shifted value is < 2*divisor and one extra bit suffices
    always_comb begin
        shifted = {rem_in, q_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[W];
        rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/nios2_div_cell.sv
// rtl/nios2_div_cell.sv - multi-cycle 32/32 divider; NIOS2_DIV_ZERO_EXC_EN adds A_div_exc
module nios2_div_cell
    import nios2_div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int ITERS  = DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              A_div_start,
    input  logic              A_div_signed,
    input  logic [DATA_W-1:0] A_div_src1,
    input  logic [DATA_W-1:0] A_div_src2,
    input  logic              A_div_kill,
    output logic              A_div_busy,
    output logic              A_div_done,
`ifdef NIOS2_DIV_ZERO_EXC_EN
    output logic              A_div_exc,
`endif
    output logic [DATA_W-1:0] A_div_cell_result,
    output logic [DATA_W-1:0] A_div_cell_remainder
);

    localparam int CNT_W = $clog2(ITERS);

    div_state_e        state;
    div_state_e        state_nxt;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              is_signed;
    logic              div0;
    logic              sign_q;
    logic              sign_r;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] divisor;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] step_rem;
    logic              step_q;
    logic              accept;
    logic              last_step;

    assign accept     = (state == IDLE) && A_div_start && !A_div_kill;
    assign last_step  = (cnt == CNT_W'(ITERS - 1));
    assign A_div_busy = (state != IDLE);

    nios2_div_step #(.W(DATA_W)) u_step (
        .rem_in  (rem),
        .q_in    (quot[DATA_W-1]),
        .divisor (divisor),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
`ifdef NIOS2_DIV_ZERO_EXC_EN
                    state_nxt = (A_div_src2 == '0) ? FIXUP : PREP;
`else
                    state_nxt = PREP;
`endif
                end
            end
            PREP:  state_nxt = CALC;
            CALC:  if (last_step) state_nxt = FIXUP;
            FIXUP: state_nxt = IDLE;
        endcase
        if (state != IDLE && A_div_kill) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op1                  <= '0;
            op2                  <= '0;
            is_signed            <= 1'b0;
            div0                 <= 1'b0;
            sign_q               <= 1'b0;
            sign_r               <= 1'b0;
            rem                  <= '0;
            quot                 <= '0;
            divisor              <= '0;
            cnt                  <= '0;
            A_div_done           <= 1'b0;
`ifdef NIOS2_DIV_ZERO_EXC_EN
            A_div_exc            <= 1'b0;
`endif
            A_div_cell_result    <= '0;
            A_div_cell_remainder <= '0;
        end else begin
            A_div_done <= 1'b0;
`ifdef NIOS2_DIV_ZERO_EXC_EN
            A_div_exc  <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op1       <= A_div_src1;
                        op2       <= A_div_src2;
                        is_signed <= A_div_signed;
                        div0      <= (A_div_src2 == '0);
                    end
                end
                PREP: begin
                    sign_q  <= is_signed & (op1[DATA_W-1] ^ op2[DATA_W-1]);
                    sign_r  <= is_signed & op1[DATA_W-1];
                    quot    <= (is_signed && op1[DATA_W-1]) ? -op1 : op1;
                    divisor <= (is_signed && op2[DATA_W-1]) ? -op2 : op2;
                    rem     <= '0;
                    cnt     <= '0;
                end
                CALC: begin
                    rem  <= step_rem;
                    quot <= {quot[DATA_W-2:0], step_q};
                    cnt  <= cnt + 1'b1;
                end
                FIXUP: begin
                    // most-negative / -1 needs no special case: the magnitude quotient is already 0x80..0
                    if (!A_div_kill) begin
                        A_div_done <= 1'b1;
                        if (div0) begin
                            A_div_cell_result    <= '1;
                            A_div_cell_remainder <= op1;
                        end else begin
                            A_div_cell_result    <= sign_q ? -quot : quot;
                            A_div_cell_remainder <= sign_r ? -rem : rem;
                        end
`ifdef NIOS2_DIV_ZERO_EXC_EN
                        A_div_exc <= div0;
`endif
                    end
                end
            endcase
        end
    end

endmodule
